// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, registered carry, LSB first.
// A start/busy/done handshake wraps each WIDTH-cycle operation.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             c_q;
    logic [CW-1:0]    cnt;

    logic             load;
    logic             step;
    logic             last_bit;
    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] sum_shift;

    // Full-adder cell on the current LSBs plus the partial-sum shift value
    always_comb begin
        s_bit     = a_sr[0] ^ b_sr[0] ^ c_q;
        c_next    = (a_sr[0] & b_sr[0]) | (a_sr[0] & c_q) | (b_sr[0] & c_q);
        last_bit  = (cnt == CW'(WIDTH - 1));
        sum_shift = sum >> 1;
        sum_shift[WIDTH-1] = s_bit;
    end

    // Next-state and datapath control
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (last_bit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture, bit-serial shifting and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            c_q      <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else if (load) begin
            a_sr <= a;
            b_sr <= sub ? ~b : b;
            c_q  <= sub | cin;
            cnt  <= '0;
        end else if (step) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            c_q  <= c_next;
            cnt  <= cnt + CW'(1);
            sum  <= sum_shift;
            if (last_bit) begin
                carry    <= c_next;
                overflow <= c_q ^ c_next;
            end
        end
    end

    // Handshake outputs, registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == S_RUN);
            done <= (state_next == S_DONE);
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=1 with a result scoreboard.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start8, cin8, sub8;
    logic [7:0] a8, b8, sum8;
    logic       carry8, ovf8, busy8, done8;

    logic       start1, cin1, sub1;
    logic [0:0] a1, b1, sum1;
    logic       carry1, ovf1, busy1, done1;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .sum(sum8), .carry(carry8), .overflow(ovf8), .busy(busy8), .done(done8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .sum(sum1), .carry(carry1), .overflow(ovf1), .busy(busy1), .done(done1)
    );

    typedef struct {
        logic [7:0] sum;
        logic       carry;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push(input logic [7:0] s, input logic c, input logic v);
        exp_t e;
        e.sum = s; e.carry = c; e.ovf = v;
        sb.push_back(e);
    endtask

    // Drive a one-cycle start pulse; returns at the negedge after the capture edge
    task automatic launch(input bit sel, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub);
        @(negedge clk);
        if (sel) begin
            a1 = a[0]; b1 = b[0]; cin1 = cin; sub1 = sub; start1 = 1'b1;
        end else begin
            a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
        end
        @(negedge clk);
        start1 = 1'b0;
        start8 = 1'b0;
    endtask

    // Wait (bounded) for done; cyc=1 at the current negedge
    task automatic wait_done(input bit sel, output int cyc, output int bcyc);
        logic d, bz, both;
        cyc = 1; bcyc = 0; both = 1'b0;
        forever begin
            d  = sel ? done1 : done8;
            bz = sel ? busy1 : busy8;
            if (d & bz) both = 1'b1;
            if (d || cyc >= 40) break;
            if (bz) bcyc++;
            @(negedge clk);
            cyc++;
        end
        chk("busy_done_exclusive", 64'(both), 64'(0));
        if (!d) chk("done_timeout", 64'(d), 64'(1));
    endtask

    task automatic pop_check(input bit sel, input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb.size()), 64'(1));
        end else begin
            e = sb.pop_front();
            if (sel) begin
                chk({tag, "_sum"},   64'(sum1),   64'(e.sum));
                chk({tag, "_carry"}, 64'(carry1), 64'(e.carry));
                chk({tag, "_ovf"},   64'(ovf1),   64'(e.ovf));
            end else begin
                chk({tag, "_sum"},   64'(sum8),   64'(e.sum));
                chk({tag, "_carry"}, 64'(carry8), 64'(e.carry));
                chk({tag, "_ovf"},   64'(ovf8),   64'(e.ovf));
            end
        end
    endtask

    // One-bit reference using the sign rule for overflow
    function automatic exp_t model1(input logic a, input logic b, input logic cin, input logic sub);
        exp_t       e;
        logic       bb;
        logic [1:0] r;
        bb = sub ? ~b : b;
        r  = 2'(a) + 2'(bb) + 2'(sub ? 1'b1 : cin);
        e.sum   = 8'(r[0]);
        e.carry = r[1];
        e.ovf   = (a == bb) && (r[0] != a);
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc, bc, seen;
        exp_t e;

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
        #1;
        chk("rst_sum",   64'(sum8),   64'(0));
        chk("rst_carry", 64'(carry8), 64'(0));
        chk("rst_ovf",   64'(ovf8),   64'(0));
        chk("rst_busy",  64'(busy8),  64'(0));
        chk("rst_done",  64'(done8),  64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Basic add with latency/busy/done-pulse checks
        push(8'h41, 1'b0, 1'b0);
        launch(0, 8'h3C, 8'h05, 1'b0, 1'b0);
        chk("busy_after_start", 64'(busy8), 64'(1));
        wait_done(0, cyc, bc);
        chk("latency", 64'(cyc - 1), 64'(8));
        chk("busy_cycles", 64'(bc), 64'(8));
        pop_check(0, "add_3c_05");
        @(negedge clk);
        chk("done_one_cycle", 64'(done8), 64'(0));
        chk("busy_idle", 64'(busy8), 64'(0));
        repeat (3) @(negedge clk);
        chk("sum_hold_idle", 64'(sum8), 64'(8'h41));

        push(8'h00, 1'b1, 1'b0);
        launch(0, 8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done(0, cyc, bc);
        pop_check(0, "add_ff_01");

        push(8'h80, 1'b0, 1'b1);
        launch(0, 8'h7F, 8'h01, 1'b0, 1'b0);
        wait_done(0, cyc, bc);
        pop_check(0, "add_7f_01");

        push(8'hFE, 1'b0, 1'b0);
        launch(0, 8'h05, 8'h07, 1'b1, 1'b1);
        wait_done(0, cyc, bc);
        pop_check(0, "sub_05_07");

        push(8'h7F, 1'b1, 1'b1);
        launch(0, 8'h80, 8'h01, 1'b0, 1'b1);
        wait_done(0, cyc, bc);
        pop_check(0, "sub_80_01");

        // Reset in the 4th RUN cycle
        launch(0, 8'h3C, 8'h05, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("carry_held_in_run", 64'(carry8), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst_sum",   64'(sum8),   64'(0));
        chk("midrst_carry", 64'(carry8), 64'(0));
        chk("midrst_ovf",   64'(ovf8),   64'(0));
        chk("midrst_busy",  64'(busy8),  64'(0));
        chk("midrst_done",  64'(done8),  64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) seen++;
        end
        chk("no_done_after_rst", 64'(seen), 64'(0));
        push(8'h41, 1'b0, 1'b0);
        launch(0, 8'h3C, 8'h05, 1'b0, 1'b0);
        wait_done(0, cyc, bc);
        pop_check(0, "post_rst");

        // Start pulse and operand changes during RUN are ignored
        push(8'h30, 1'b0, 1'b0);
        launch(0, 8'h10, 8'h20, 1'b0, 1'b0);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done(0, cyc, bc);
        pop_check(0, "ignore_run");
        @(negedge clk);
        chk("ignore_run_idle", 64'(busy8), 64'(0));

        // Back-to-back with start held high through DONE
        push(8'h33, 1'b0, 1'b0);
        push(8'h0B, 1'b0, 1'b0);
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        wait_done(0, cyc, bc);
        pop_check(0, "b2b_first");
        a8 = 8'h05; b8 = 8'h06;
        @(negedge clk);
        start8 = 1'b0;
        chk("b2b_busy_again", 64'(busy8), 64'(1));
        wait_done(0, cyc, bc);
        chk("b2b_done_spacing", 64'(cyc), 64'(9));
        pop_check(0, "b2b_second");

        // WIDTH=1 exhaustive
        for (int i = 0; i < 16; i++) begin
            logic ta, tb, tc, ts;
            ta = i[0]; tb = i[1]; tc = i[2]; ts = i[3];
            e = model1(ta, tb, tc, ts);
            sb.push_back(e);
            launch(1, 8'(ta), 8'(tb), tc, ts);
            wait_done(1, cyc, bc);
            chk($sformatf("w1_latency_%0d", i), 64'(cyc - 1), 64'(1));
            pop_check(1, $sformatf("w1_%0d", i));
            if (!tc && !ts) begin
                chk($sformatf("w1_ha_sum_%0d", i),   64'(sum1),   64'(ta ^ tb));
                chk($sformatf("w1_ha_carry_%0d", i), 64'(carry1), 64'(ta & tb));
            end
        end

        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
